// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register chain with bubble collapse.
// Each stage holds one word and a valid bit. A stage loads from its upstream
// neighbour whenever it is empty or the stage after it is advancing, so
// invalid stages never hold back traffic.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every stage and the count
//   flush      synchronous clear of every stage; blocks the input that cycle
//   in_valid   upstream word present on in_data
//   in_ready   chain can accept a word this cycle (combinational)
//   in_data    upstream word
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   out_data   word in the last stage, zero when out_valid is low
//   occupancy  registered count of valid stages
module pipe_reg_chain #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             accept;
    logic             retire;

    // Per-stage ready and load source. The ready recurrence
    // r[i] = !v[i] | r[i+1] is written unrolled: a stage can move when any
    // stage from it to the output is empty, or the output is being drained.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign r[i] = out_ready | ~(&v[DEPTH-1:i]);
        if (i == 0) begin : g_first
            assign src_v[i] = in_valid;
            assign src_d[i] = in_data;
        end else begin : g_next
            assign src_v[i] = v[i-1];
            assign src_d[i] = d[i-1];
        end
    end

    // Stage registers: flush wins over every handshake; stalled stages hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (flush) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= src_v[i];
                    d[i] <= src_d[i];
                end
            end
        end
    end

    assign in_ready  = r[0] & ~flush & ~rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = v[DEPTH-1] ? d[DEPTH-1] : '0;

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // Occupancy tracks handshakes rather than re-counting the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
